branch_pc_unit: RTL and testbench

- Downstream consumer of the ALU's zero/sign/carry/overflow flags in the single-cycle RISC CPU.
- Holds the architectural flag register, program counter and link (return) state.
- Resolves conditional/unconditional branches, call, return and register-indirect jumps.
- Drives the fetch address every cycle.

---
 rtl/branch_pc_unit.sv | 176 +++++++++++++++++
 tb/tb_branch_pc_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_pc_unit.sv
// Program counter, flag register and link/return-stack state for the single-cycle CPU.
// Optional macro BRANCH_RAS_EN replaces the single link register with a circular return stack.
module branch_pc_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flag_we,
    input  logic        zeroflag_in,
    input  logic        signflag_in,
    input  logic        carryflag_in,
    input  logic        overflowflag_in,
    input  logic [3:0]  br_op,
    input  logic [31:0] br_offset,
    input  logic [31:0] reg_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        taken,
    output logic [3:0]  flags_q,
    output logic [31:0] link_q,
    output logic        ras_err
);

    localparam logic [3:0] OP_BR   = 4'b0001;
    localparam logic [3:0] OP_BZ   = 4'b0010;
    localparam logic [3:0] OP_BNZ  = 4'b0011;
    localparam logic [3:0] OP_BC   = 4'b0100;
    localparam logic [3:0] OP_BNC  = 4'b0101;
    localparam logic [3:0] OP_BS   = 4'b0110;
    localparam logic [3:0] OP_BNS  = 4'b0111;
    localparam logic [3:0] OP_BV   = 4'b1000;
    localparam logic [3:0] OP_BNV  = 4'b1001;
    localparam logic [3:0] OP_CALL = 4'b1010;
    localparam logic [3:0] OP_RET  = 4'b1011;
    localparam logic [3:0] OP_JR   = 4'b1100;

    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic [3:0]  flags_reg;
    logic        cond_taken;
    logic [31:0] rel_target;
    logic [31:0] ret_target;
    logic [31:0] raw_target;
    logic [31:0] target;
    logic        is_call;
    logic        is_ret;

    // flags_reg layout is {Z, S, C, V}
    logic flag_z, flag_s, flag_c, flag_v;
    assign {flag_z, flag_s, flag_c, flag_v} = flags_reg;

    assign pc       = pc_reg;
    assign flags_q  = flags_reg;
    assign pc_plus4 = pc_reg + 32'd4;

    always_comb begin
        cond_taken = 1'b0;
        case (br_op)
            OP_BR, OP_CALL, OP_RET, OP_JR: cond_taken = 1'b1;
            OP_BZ:   cond_taken = flag_z;
            OP_BNZ:  cond_taken = ~flag_z;
            OP_BC:   cond_taken = flag_c;
            OP_BNC:  cond_taken = ~flag_c;
            OP_BS:   cond_taken = flag_s;
            OP_BNS:  cond_taken = ~flag_s;
            OP_BV:   cond_taken = flag_v;
            OP_BNV:  cond_taken = ~flag_v;
            default: cond_taken = 1'b0;
        endcase
    end

    assign taken   = cond_taken & ~stall;
    assign is_call = (br_op == OP_CALL) & ~stall;
    assign is_ret  = (br_op == OP_RET) & ~stall;

    assign rel_target = pc_plus4 + br_offset;

    always_comb begin
        raw_target = rel_target;
        case (br_op)
            OP_RET:  raw_target = ret_target;
            OP_JR:   raw_target = reg_target;
            default: raw_target = rel_target;
        endcase
    end

    assign target  = {raw_target[31:2], 2'b00};
    assign pc_next = taken ? target : pc_plus4;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg    <= RESET_PC;
            flags_reg <= 4'b0000;
        end else if (!stall) begin
            pc_reg <= pc_next;
            if (flag_we) begin
                flags_reg <= {zeroflag_in, signflag_in, carryflag_in, overflowflag_in};
            end
        end
    end

`ifdef BRANCH_RAS_EN
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [31:0]   ras_mem [RAS_DEPTH];
    logic [PW-1:0] ptr_reg;
    logic [CW-1:0] count_reg;
    logic [31:0]   top_reg;
    logic          err_reg;
    logic          ras_full;
    logic          ras_empty;

    assign ras_full   = (count_reg == CW'(RAS_DEPTH));
    assign ras_empty  = (count_reg == '0);
    assign ret_target = ras_empty ? RESET_PC : top_reg;
    assign link_q     = top_reg;
    assign ras_err    = err_reg;

    // Storage kept free of reset so it maps onto a RAM; count alone defines validity.
    always_ff @(posedge clk) begin
        if (!rst && is_call) begin
            ras_mem[ptr_reg] <= pc_plus4;
        end
    end

    // ptr_reg is the next write slot; a push when full simply overwrites the oldest entry.
    // top_reg mirrors the newest entry so link_q comes straight from a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg   <= '0;
            count_reg <= '0;
            top_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            err_reg <= 1'b0;
            if (is_call) begin
                ptr_reg <= ptr_reg + PW'(1);
                top_reg <= pc_plus4;
                if (ras_full) begin
                    err_reg <= 1'b1;
                end else begin
                    count_reg <= count_reg + CW'(1);
                end
            end else if (is_ret) begin
                if (ras_empty) begin
                    err_reg <= 1'b1;
                end else begin
                    ptr_reg   <= ptr_reg - PW'(1);
                    count_reg <= count_reg - CW'(1);
                    top_reg   <= (count_reg == CW'(1)) ? 32'd0 : ras_mem[ptr_reg - PW'(2)];
                end
            end
        end
    end
`else
    logic [31:0] link_reg;
    logic [31:0] unused_ras_depth;

    assign unused_ras_depth = 32'(RAS_DEPTH);
    assign ret_target       = link_reg;
    assign link_q           = link_reg;
    assign ras_err          = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            link_reg <= 32'd0;
        end else if (is_call) begin
            link_reg <= pc_plus4;
        end
    end
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_branch_pc_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          RAS_DEPTH = 4;
`ifdef BRANCH_RAS_EN
    localparam bit RAS_MODE = 1'b1;
`else
    localparam bit RAS_MODE = 1'b0;
`endif

    localparam logic [3:0] OP_NONE = 4'b0000;
    localparam logic [3:0] OP_BR   = 4'b0001;
    localparam logic [3:0] OP_BZ   = 4'b0010;
    localparam logic [3:0] OP_BNZ  = 4'b0011;
    localparam logic [3:0] OP_CALL = 4'b1010;
    localparam logic [3:0] OP_RET  = 4'b1011;
    localparam logic [3:0] OP_JR   = 4'b1100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        flag_we = 1'b0;
    logic        zf = 1'b0, sf = 1'b0, cf = 1'b0, vf = 1'b0;
    logic [3:0]  br_op = 4'b0;
    logic [31:0] br_offset = 32'b0;
    logic [31:0] reg_target = 32'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        taken;
    logic [3:0]  flags_q;
    logic [31:0] link_q;
    logic        ras_err;

    branch_pc_unit #(.RESET_PC(RESET_PC), .RAS_DEPTH(RAS_DEPTH)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flag_we(flag_we),
        .zeroflag_in(zf), .signflag_in(sf), .carryflag_in(cf), .overflowflag_in(vf),
        .br_op(br_op), .br_offset(br_offset), .reg_target(reg_target),
        .pc(pc), .pc_plus4(pc_plus4), .taken(taken), .flags_q(flags_q),
        .link_q(link_q), .ras_err(ras_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference state
    logic [31:0] m_pc = RESET_PC;
    logic [31:0] m_link = 32'd0;
    logic [3:0]  m_flags = 4'd0;
    logic        m_err = 1'b0;
    logic [31:0] m_stack[$];

    logic        obs_taken, exp_taken;
    logic [31:0] obs_plus4, exp_plus4;

    function automatic bit model_cond(input logic [3:0] op);
        bit z, s, c, v;
        {z, s, c, v} = m_flags;
        case (op)
            4'd1, 4'd10, 4'd11, 4'd12: return 1'b1;
            4'd2: return z;
            4'd3: return !z;
            4'd4: return c;
            4'd5: return !c;
            4'd6: return s;
            4'd7: return !s;
            4'd8: return v;
            4'd9: return !v;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_link();
        if (RAS_MODE) return (m_stack.size() > 0) ? m_stack[$] : 32'd0;
        return m_link;
    endfunction

    // Drives one cycle, samples combinational outputs before the edge, advances the model.
    task automatic cycle(input bit r, input bit s, input bit fwe, input logic [3:0] f,
                         input logic [3:0] op, input logic [31:0] off, input logic [31:0] tgt);
        logic [31:0] dest;
        @(negedge clk);
        rst = r; stall = s; flag_we = fwe; {zf, sf, cf, vf} = f;
        br_op = op; br_offset = off; reg_target = tgt;
        #1;
        obs_taken = taken;
        obs_plus4 = pc_plus4;
        exp_taken = !s && model_cond(op);
        exp_plus4 = m_pc + 32'd4;
        m_err = 1'b0;
        if (r) begin
            m_pc = RESET_PC; m_flags = 4'd0; m_link = 32'd0; m_stack.delete();
        end else if (!s) begin
            dest = m_pc + 32'd4 + off;
            if (op == OP_JR) dest = tgt;
            if (op == OP_RET) begin
                if (!RAS_MODE) dest = m_link;
                else if (m_stack.size() == 0) begin dest = RESET_PC; m_err = 1'b1; end
                else dest = m_stack.pop_back();
            end
            if (op == OP_CALL) begin
                if (!RAS_MODE) m_link = m_pc + 32'd4;
                else begin
                    if (m_stack.size() == RAS_DEPTH) begin
                        void'(m_stack.pop_front());
                        m_err = 1'b1;
                    end
                    m_stack.push_back(m_pc + 32'd4);
                end
            end
            m_pc = exp_taken ? {dest[31:2], 2'b00} : m_pc + 32'd4;
            if (fwe) m_flags = f;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 4'h0, OP_NONE, 0, 0);
        checks++; if (pc !== RESET_PC) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, RESET_PC); end
        checks++; if (flags_q !== 4'h0) begin failures++; $display("FAIL reset_flags got=%h exp=0", flags_q); end
        checks++; if (link_q !== 32'h0) begin failures++; $display("FAIL reset_link got=%h exp=0", link_q); end
        checks++; if (ras_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", ras_err); end
        for (int k = 1; k <= 3; k++) begin
            cycle(0, 0, 0, 4'h0, OP_NONE, 0, 0);
            checks++; if (obs_taken !== 1'b0) begin failures++; $display("FAIL seq_taken k=%0d got=%b exp=0", k, obs_taken); end
            checks++; if (pc !== 32'(4 * k)) begin failures++; $display("FAIL seq_pc k=%0d got=%h exp=%h", k, pc, 32'(4 * k)); end
        end
        $display("test_reset done pc=%h", pc);
    endtask

    task automatic test_cond_branch();
        cycle(0, 0, 1, 4'b1000, OP_NONE, 0, 0);   // pc 0xC -> 0x10, Z latched
        checks++; if (flags_q !== 4'b1000) begin failures++; $display("FAIL cond_flags got=%h exp=8", flags_q); end
        cycle(0, 0, 0, 4'h0, OP_BZ, 32'h20, 0);
        checks++; if (obs_taken !== 1'b1) begin failures++; $display("FAIL bz_taken got=%b exp=1", obs_taken); end
        checks++; if (pc !== 32'h34) begin failures++; $display("FAIL bz_pc got=%h exp=00000034", pc); end
        cycle(0, 0, 1, 4'b0000, OP_NONE, 0, 0);   // clear Z
        cycle(0, 0, 1, 4'b1000, OP_BZ, 32'h20, 0); // same-cycle flag write must not count
        checks++; if (obs_taken !== 1'b0) begin failures++; $display("FAIL bz_same_cycle_taken got=%b exp=0", obs_taken); end
        checks++; if (pc !== 32'h3C) begin failures++; $display("FAIL bz_same_cycle_pc got=%h exp=0000003c", pc); end
        cycle(0, 0, 0, 4'h0, OP_BNZ, 32'h100, 0);
        checks++; if (obs_taken !== 1'b0 || pc !== 32'h40) begin failures++; $display("FAIL bnz_pc got=%h/%b exp=00000040/0", pc, obs_taken); end
        $display("test_cond_branch done pc=%h", pc);
    endtask

    task automatic test_call_ret();
        cycle(0, 0, 0, 4'h0, OP_JR, 0, 32'h100);
        cycle(0, 0, 0, 4'h0, OP_CALL, 32'hFFFF_FEFC, 0);
        checks++; if (pc !== 32'h0 || link_q !== 32'h104) begin failures++; $display("FAIL call got pc=%h link=%h exp pc=0 link=104", pc, link_q); end
        cycle(0, 0, 0, 4'h0, OP_NONE, 0, 0);
        cycle(0, 0, 0, 4'h0, OP_RET, 0, 0);
        checks++; if (pc !== 32'h104) begin failures++; $display("FAIL ret_pc got=%h exp=00000104", pc); end
        checks++; if (link_q !== model_link()) begin failures++; $display("FAIL ret_link got=%h exp=%h", link_q, model_link()); end
        $display("test_call_ret done pc=%h", pc);
    endtask

    task automatic test_jr_wrap();
        cycle(0, 0, 0, 4'h0, OP_JR, 0, 32'h1237);
        checks++; if (pc !== 32'h1234) begin failures++; $display("FAIL jr_pc got=%h exp=00001234", pc); end
        cycle(0, 0, 0, 4'h0, OP_JR, 0, 32'hFFFF_FFFC);
        cycle(0, 0, 0, 4'h0, OP_BR, 32'h0, 0);
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL br_wrap_pc got=%h exp=0", pc); end
        $display("test_jr_wrap done pc=%h", pc);
    endtask

    task automatic test_stall();
        logic [31:0] hold_pc, hold_link;
        logic [3:0]  hold_flags;
        hold_pc = pc; hold_link = link_q; hold_flags = flags_q;
        for (int k = 0; k < 2; k++) begin
            cycle(0, 1, 1, ~hold_flags, OP_BR, 32'h40, 0);
            checks++; if (obs_taken !== 1'b0) begin failures++; $display("FAIL stall_taken k=%0d got=%b exp=0", k, obs_taken); end
            checks++; if (pc !== hold_pc || flags_q !== hold_flags || link_q !== hold_link)
                begin failures++; $display("FAIL stall_hold k=%0d got pc=%h f=%h l=%h exp pc=%h f=%h l=%h", k, pc, flags_q, link_q, hold_pc, hold_flags, hold_link); end
        end
        cycle(0, 0, 0, 4'h0, OP_NONE, 0, 0);
        cycle(1, 1, 0, 4'h0, OP_BR, 32'h40, 0);
        checks++; if (pc !== RESET_PC) begin failures++; $display("FAIL stall_reset_pc got=%h exp=%h", pc, RESET_PC); end
        $display("test_stall done pc=%h", pc);
    endtask

    task automatic test_random();
        logic [31:0] off;
        for (int i = 0; i < 400; i++) begin
            off = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 255) * 4) - 32'd512;
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0), $urandom_range(0, 1),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), off, 32'($urandom));
            checks++; if (obs_taken !== exp_taken) begin failures++; $display("FAIL rnd_taken i=%0d got=%b exp=%b", i, obs_taken, exp_taken); end
            checks++; if (obs_plus4 !== exp_plus4) begin failures++; $display("FAIL rnd_pc_plus4 i=%0d got=%h exp=%h", i, obs_plus4, exp_plus4); end
            checks++; if (pc !== m_pc) begin failures++; $display("FAIL rnd_pc i=%0d got=%h exp=%h", i, pc, m_pc); end
            checks++; if (flags_q !== m_flags) begin failures++; $display("FAIL rnd_flags i=%0d got=%h exp=%h", i, flags_q, m_flags); end
            checks++; if (link_q !== model_link()) begin failures++; $display("FAIL rnd_link i=%0d got=%h exp=%h", i, link_q, model_link()); end
            checks++; if (ras_err !== m_err) begin failures++; $display("FAIL rnd_ras_err i=%0d got=%b exp=%b", i, ras_err, m_err); end
        end
        $display("test_random done cycles=400 pc=%h", pc);
    endtask

`ifdef BRANCH_RAS_EN
    task automatic test_ras();
        logic [31:0] links [5];
        cycle(1, 0, 0, 4'h0, OP_NONE, 0, 0);
        for (int k = 0; k < 5; k++) begin
            links[k] = pc + 32'd4;
            cycle(0, 0, 0, 4'h0, OP_CALL, 32'(64 * (k + 1)), 0);
            checks++; if (ras_err !== (k == 4)) begin failures++; $display("FAIL ras_push_err k=%0d got=%b exp=%b", k, ras_err, (k == 4)); end
        end
        cycle(0, 0, 0, 4'h0, OP_NONE, 0, 0);
        checks++; if (ras_err !== 1'b0) begin failures++; $display("FAIL ras_err_pulse got=%b exp=0", ras_err); end
        for (int j = 0; j < 4; j++) begin
            cycle(0, 0, 0, 4'h0, OP_RET, 0, 0);
            checks++; if (pc !== links[4 - j] || ras_err !== 1'b0) begin failures++; $display("FAIL ras_pop j=%0d got=%h/%b exp=%h/0", j, pc, ras_err, links[4 - j]); end
        end
        checks++; if (link_q !== 32'h0) begin failures++; $display("FAIL ras_empty_link got=%h exp=0", link_q); end
        cycle(0, 0, 0, 4'h0, OP_RET, 0, 0);
        checks++; if (pc !== RESET_PC || ras_err !== 1'b1) begin failures++; $display("FAIL ras_underflow got=%h/%b exp=%h/1", pc, ras_err, RESET_PC); end
        $display("test_ras done pc=%h", pc);
    endtask
`endif

    initial begin
        test_reset();
        test_cond_branch();
        test_call_ret();
        test_jr_wrap();
        test_stall();
`ifdef BRANCH_RAS_EN
        test_ras();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
